// File: rtl/axi_pseudo_mem.sv
// AXI4 slave memory model: independent write/read engines, INCR bursts, fixed read latency.
// Define AXI_PSEUDO_MEM_DECERR_EN to answer out-of-window start addresses with DECERR.
module axi_pseudo_mem #(
    parameter int unsigned ADDR_W     = 40,
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned ID_W       = 16,
    parameter int unsigned DEPTH_LOG2 = 16,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic                pl_clk0,
    input  logic                pl_aresetn,
    input  logic [ID_W-1:0]     s_awid,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic [7:0]          s_awlen,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [ID_W-1:0]     s_bid,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ID_W-1:0]     s_arid,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic [7:0]          s_arlen,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [ID_W-1:0]     s_rid,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                s_rvalid,
    input  logic                s_rready
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = DEPTH_LOG2;
    localparam int unsigned WORDS  = 1 << DEPTH_LOG2;
    localparam int unsigned LAT_W  = 4;
    localparam int unsigned LEN_W  = 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

    logic [DATA_W-1:0] mem [WORDS];

    w_state_e          w_state_q;
    logic              awready_q, wready_q, bvalid_q, w_err_q;
    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q;
    logic [IDX_W-1:0]  w_idx_q;
    logic [LEN_W-1:0]  w_len_q, w_cnt_q;

    r_state_e          r_state_q;
    logic              arready_q, rvalid_q, rlast_q, r_err_q;
    logic [ID_W-1:0]   rid_q;
    logic [1:0]        rresp_q;
    logic [DATA_W-1:0] rdata_q;
    logic [IDX_W-1:0]  r_idx_q;
    logic [LEN_W-1:0]  r_len_q, r_cnt_q;
    logic [LAT_W-1:0]  lat_q;

    logic [IDX_W-1:0]  aw_idx_c, ar_idx_c;
    logic              aw_oow_c, ar_oow_c;

    assign aw_idx_c = s_awaddr[OFF+DEPTH_LOG2-1:OFF];
    assign ar_idx_c = s_araddr[OFF+DEPTH_LOG2-1:OFF];

`ifdef AXI_PSEUDO_MEM_DECERR_EN
    assign aw_oow_c = |s_awaddr[ADDR_W-1:OFF+DEPTH_LOG2];
    assign ar_oow_c = |s_araddr[ADDR_W-1:OFF+DEPTH_LOG2];
`else
    assign aw_oow_c = 1'b0;
    assign ar_oow_c = 1'b0;
`endif

    // Byte-offset bits are meaningless for full-width beats; upper bits only matter for DECERR.
    logic unused_c;
    assign unused_c = &{1'b0, s_awaddr[OFF-1:0], s_araddr[OFF-1:0],
                        s_awaddr[ADDR_W-1:OFF+DEPTH_LOG2], s_araddr[ADDR_W-1:OFF+DEPTH_LOG2]};

    // Write engine
    always_ff @(posedge pl_clk0 or negedge pl_aresetn) begin
        if (!pl_aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            w_err_q   <= 1'b0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: if (s_awvalid && awready_q) begin
                    bid_q     <= s_awid;
                    w_idx_q   <= aw_idx_c;
                    w_len_q   <= s_awlen;
                    w_cnt_q   <= '0;
                    w_err_q   <= aw_oow_c;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b1;
                    w_state_q <= W_DATA;
                end
                W_DATA: if (s_wvalid) begin
                    w_idx_q <= w_idx_q + IDX_W'(1);
                    w_cnt_q <= w_cnt_q + LEN_W'(1);
                    if (w_cnt_q == w_len_q) begin
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= w_err_q ? 2'b11 : 2'b00;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: if (s_bready) begin
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    w_state_q <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Memory array is deliberately unreset so contents survive pl_aresetn
    always_ff @(posedge pl_clk0) begin
        if (wready_q && s_wvalid && !w_err_q) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (s_wstrb[b]) mem[w_idx_q][b*8 +: 8] <= s_wdata[b*8 +: 8];
            end
        end
    end

    // Read engine; rdata is fetched one edge ahead so a colliding write is not seen
    always_ff @(posedge pl_clk0 or negedge pl_aresetn) begin
        if (!pl_aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            r_err_q   <= 1'b0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            lat_q     <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: if (s_arvalid && arready_q) begin
                    rid_q     <= s_arid;
                    r_idx_q   <= ar_idx_c;
                    r_len_q   <= s_arlen;
                    r_cnt_q   <= '0;
                    r_err_q   <= ar_oow_c;
                    lat_q     <= '0;
                    arready_q <= 1'b0;
                    if (RD_LAT == 0) begin
                        rvalid_q  <= 1'b1;
                        rlast_q   <= (s_arlen == '0);
                        rresp_q   <= ar_oow_c ? 2'b11 : 2'b00;
                        rdata_q   <= ar_oow_c ? '0 : mem[ar_idx_c];
                        r_state_q <= R_DATA;
                    end else begin
                        r_state_q <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (lat_q == LAT_W'(RD_LAT - 1)) begin
                        rvalid_q  <= 1'b1;
                        rlast_q   <= (r_len_q == '0);
                        rresp_q   <= r_err_q ? 2'b11 : 2'b00;
                        rdata_q   <= r_err_q ? '0 : mem[r_idx_q];
                        r_state_q <= R_DATA;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                R_DATA: if (s_rready) begin
                    if (rlast_q) begin
                        rvalid_q  <= 1'b0;
                        rlast_q   <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end else begin
                        r_idx_q <= r_idx_q + IDX_W'(1);
                        r_cnt_q <= r_cnt_q + LEN_W'(1);
                        rlast_q <= ((r_cnt_q + LEN_W'(1)) == r_len_q);
                        rdata_q <= r_err_q ? '0 : mem[r_idx_q + IDX_W'(1)];
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bid     = bid_q;
    assign s_bresp   = bresp_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rlast   = rlast_q;
    assign s_rid     = rid_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;

endmodule
